time_mgr: RTL
=============

Name: time_mgr

Overview:
Consumer end of the PCParser -> TimeMgr control path.
- Turns the parser's reset_time, unit_len and PC_time_elapsed into an FPGA time base: a cycle counter, a time-unit pulse and a time_elapsed counter.
- Produces a stall for downstream stream traffic that the PC scheduled in the future.
- Optionally reports time upstream to the host over a ready/valid heartbeat channel.

Parameters:
Nunit, 16, width of unit_len and of the cycle counter
Ntime, 40, width of the time-unit counter and of PC_time_elapsed
HB_LOG2, 4, heartbeat every 2^HB_LOG2 time units

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous, active-low reset
reset_time  in  1  one-cycle pulse; zero all time state
unit_len  in  Nunit  time-unit length in clk cycles; level, may change at any time
PC_time_elapsed  in  Ntime  time at which the PC intends subsequent stream elements to be sent, in units
time_unit_pulse  out  1  one-cycle pulse at each unit boundary
time_elapsed  out  Ntime  FPGA time in units
stall_dn  out  1  high while PC_time_elapsed > time_elapsed
HB_up_valid  out  1  heartbeat channel valid
HB_up_data  out  Ntime  heartbeat payload (time_elapsed snapshot)
HB_up_ready  in  1  heartbeat channel ready

Behaviour:
- Reset (reset_n low, asynchronous): cyc_cnt=0, time_elapsed=0, time_unit_pulse=0, HB_up_valid=0, HB_up_data=0. stall_dn stays combinational.
- Cycle counter, per clk edge, in priority order:
  - reset_time=1: cyc_cnt<=0, time_elapsed<=0, time_unit_pulse<=0, HB_up_valid<=0.
  - unit_len==0: timer frozen. cyc_cnt<=0, time_elapsed held, pulse<=0.
  - cyc_cnt >= unit_len-1 (unsigned): cyc_cnt<=0, time_elapsed<=time_elapsed+1, time_unit_pulse<=1.
  - Otherwise: cyc_cnt<=cyc_cnt+1, pulse<=0.
- Period: unit_len=N gives one pulse every N cycles. N=1 gives a pulse every cycle.
- Pulse alignment: the pulse and the incremented time_elapsed become visible in the same cycle.
- unit_len shrunk below the current cyc_cnt: the >= compare forces a wrap on the next edge. There is no lockout.
- time_elapsed wraps modulo 2^Ntime. No saturation.
- stall_dn = (PC_time_elapsed > time_elapsed), unsigned, combinational. Zero latency from either operand; wrap is not special-cased.
- Heartbeat event: an edge that increments time_elapsed to a value whose low HB_LOG2 bits are 0.
  - On the event: HB_up_data<=new time_elapsed, HB_up_valid<=1.
  - Transfer happens on an edge with HB_up_valid & HB_up_ready. Valid then drops unless a new event occurs on the same edge.
  - Event while a beat is still pending: data is overwritten with the newer time and valid stays 1. The stale beat is dropped.
  - Event coincident with a transfer: the old beat transfers, the new data loads, valid stays 1.
  - HB_up_data is stable whenever valid=1 and no new event occurs.

Optional Feature:
TIME_MGR_HEARTBEAT_EN
- Defined: heartbeat channel behaves as above.
- Undefined: heartbeat register logic is not built. HB_up_valid and HB_up_data are tied 0; HB_up_ready is ignored. Ports remain present so the parent is unchanged.

Decomposition:
- Package time_mgr_pkg holds the Nunit/Ntime/HB_LOG2 defaults and a typedef time_t = logic [Ntime-1:0].
- Sub-module unit_timer holds cyc_cnt, the unit_len compare, time_unit_pulse and the reset_time/freeze priority.
- time_mgr top holds time_elapsed, stall_dn and the heartbeat channel register.

Test Plan:
- Async reset mid-count, unit_len=5: reset_n low for 3 cycles, then high -> all outputs 0 immediately; first pulse 5 cycles after release, time_elapsed=1 with it.
- unit_len=4 held for 40 cycles -> 10 pulses, spaced exactly 4 cycles apart; time_elapsed=10. Change unit_len to 2 with cyc_cnt=3 -> wrap on the next edge, then period 2.
- unit_len=0 -> no pulses and time_elapsed frozen for 100 cycles. unit_len=1 -> pulse every cycle.
- PC_time_elapsed=7 with time_elapsed counting from 0 -> stall_dn=1 through time_elapsed=6, and 0 in the same cycle time_elapsed becomes 7. reset_time pulse at time_elapsed=9 -> time_elapsed=0, stall_dn=1.
- Force time_elapsed to 2^40-1 with Ntime=40 -> next pulse gives 0. With TIME_MGR_HEARTBEAT_EN this raises a heartbeat with HB_up_data=0.
- Heartbeats, HB_LOG2=2, unit_len=1, HB_up_ready=0 -> valid rises at time 4; data updates to 8, then 12, valid held. Ready=1 at time 13 -> transfer of 12, valid drops. Macro undefined -> valid stays 0 throughout.

Source files
------------

// File: rtl/time_mgr_pkg.sv
// -----------------------------------------------------------------------------
// time_mgr_pkg
// Shared defaults for the PCParser -> TimeMgr time base.
//   NUNIT_DFLT   : width of unit_len and of the per-unit cycle counter
//   NTIME_DFLT   : width of the time-unit counter and of PC_time_elapsed
//   HB_LOG2_DFLT : a heartbeat is raised every 2^HB_LOG2 time units
//   time_t       : a time value in units at the default width
// -----------------------------------------------------------------------------
package time_mgr_pkg;

  localparam int NUNIT_DFLT   = 16;
  localparam int NTIME_DFLT   = 40;
  localparam int HB_LOG2_DFLT = 4;

  typedef logic [NTIME_DFLT-1:0] time_t;

endpackage : time_mgr_pkg

// File: rtl/time_mgr_if.sv
// -----------------------------------------------------------------------------
// time_mgr_if
// Upstream heartbeat channel (ready/valid) from the time manager to the host.
//   HB_up_valid : a heartbeat beat is pending
//   HB_up_data  : time_elapsed snapshot carried by the beat
//   HB_up_ready : consumer accepts the beat on an edge where valid is high
// Modports:
//   master : the time manager (drives valid/data, observes ready)
//   slave  : the host-side consumer
// -----------------------------------------------------------------------------
interface time_mgr_if #(
  parameter int Ntime = time_mgr_pkg::NTIME_DFLT
) ();

  logic             HB_up_valid;
  logic [Ntime-1:0] HB_up_data;
  logic             HB_up_ready;

  modport master (
    output HB_up_valid,
    output HB_up_data,
    input  HB_up_ready
  );

  modport slave (
    input  HB_up_valid,
    input  HB_up_data,
    output HB_up_ready
  );

endinterface : time_mgr_if

// File: rtl/time_mgr_unit_timer.sv
// -----------------------------------------------------------------------------
// unit_timer
// Divides clk into time units of unit_len cycles.
// Ports:
//   clk             : single clock
//   reset_n         : asynchronous active-low reset
//   reset_time      : synchronous clear of all timer state (highest priority)
//   unit_len        : unit length in cycles; 0 freezes the timer
//   unit_end        : combinational, high when the coming edge closes a unit;
//                     the parent advances time_elapsed on that same edge
//   time_unit_pulse : registered one-cycle pulse, visible together with the
//                     incremented time_elapsed
// -----------------------------------------------------------------------------
module unit_timer
  import time_mgr_pkg::*;
#(
  parameter int Nunit = NUNIT_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_time,
  input  logic [Nunit-1:0] unit_len,
  output logic             unit_end,
  output logic             time_unit_pulse
);

  logic [Nunit-1:0] cyc_cnt;
  logic             frozen;

  assign frozen = (unit_len == '0);

  // A >= compare rather than == so that shrinking unit_len below the current
  // count wraps on the next edge instead of running the counter all the way
  // around its range.
  assign unit_end = !reset_time && !frozen &&
                    (cyc_cnt >= (unit_len - Nunit'(1)));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt         <= '0;
      time_unit_pulse <= 1'b0;
    end else if (reset_time || frozen) begin
      cyc_cnt         <= '0;
      time_unit_pulse <= 1'b0;
    end else if (unit_end) begin
      cyc_cnt         <= '0;
      time_unit_pulse <= 1'b1;
    end else begin
      cyc_cnt         <= cyc_cnt + Nunit'(1);
      time_unit_pulse <= 1'b0;
    end
  end

endmodule : unit_timer

// File: rtl/time_mgr.sv
// -----------------------------------------------------------------------------
// time_mgr
// Consumer end of the PCParser -> TimeMgr control path. Builds the FPGA time
// base, stalls downstream stream traffic scheduled in the future and
// optionally reports time to the host over a heartbeat channel.
// Ports:
//   clk             : single clock
//   reset_n         : asynchronous active-low reset
//   reset_time      : one-cycle pulse, zeroes all time state
//   unit_len        : time-unit length in clk cycles (level, 0 = frozen)
//   PC_time_elapsed : time at which the PC schedules following stream elements
//   time_unit_pulse : one-cycle pulse at each unit boundary
//   time_elapsed    : FPGA time in units, wraps modulo 2^Ntime
//   stall_dn        : combinational, PC_time_elapsed > time_elapsed (unsigned)
//   hb              : heartbeat channel (time_mgr_if.master)
// Build option:
//   TIME_MGR_HEARTBEAT_EN : when defined, a heartbeat carrying the new
//   time_elapsed is raised each time it reaches a multiple of 2^HB_LOG2.
//   When undefined, the channel outputs are tied low and ready is ignored.
// -----------------------------------------------------------------------------
module time_mgr
  import time_mgr_pkg::*;
#(
  parameter int Nunit   = NUNIT_DFLT,
  parameter int Ntime   = NTIME_DFLT,
  parameter int HB_LOG2 = HB_LOG2_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_time,
  input  logic [Nunit-1:0] unit_len,
  input  logic [Ntime-1:0] PC_time_elapsed,
  output logic             time_unit_pulse,
  output logic [Ntime-1:0] time_elapsed,
  output logic             stall_dn,
  time_mgr_if.master       hb
);

  logic             unit_end;
  logic [Ntime-1:0] time_next;

  unit_timer #(
    .Nunit (Nunit)
  ) u_unit_timer (
    .clk             (clk),
    .reset_n         (reset_n),
    .reset_time      (reset_time),
    .unit_len        (unit_len),
    .unit_end        (unit_end),
    .time_unit_pulse (time_unit_pulse)
  );

  // Natural modulo-2^Ntime wrap; no saturation.
  assign time_next = time_elapsed + Ntime'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_elapsed <= '0;
    end else if (reset_time) begin
      time_elapsed <= '0;
    end else if (unit_end) begin
      time_elapsed <= time_next;
    end
  end

  // Plain unsigned compare: a wrapped time_elapsed is not special-cased.
  assign stall_dn = (PC_time_elapsed > time_elapsed);

`ifdef TIME_MGR_HEARTBEAT_EN
  logic hb_event;
  logic hb_valid_q;
  logic [Ntime-1:0] hb_data_q;

  assign hb_event = unit_end && (time_next[HB_LOG2-1:0] == '0);

  // A newer event overwrites a pending beat (the stale time is dropped). An
  // event on a transfer edge lets the old beat go and loads the new one, so
  // valid stays high in both cases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_valid_q <= 1'b0;
      hb_data_q  <= '0;
    end else if (reset_time) begin
      hb_valid_q <= 1'b0;
    end else if (hb_event) begin
      hb_valid_q <= 1'b1;
      hb_data_q  <= time_next;
    end else if (hb_valid_q && hb.HB_up_ready) begin
      hb_valid_q <= 1'b0;
    end
  end

  assign hb.HB_up_valid = hb_valid_q;
  assign hb.HB_up_data  = hb_data_q;
`else
  logic hb_ready_unused;

  assign hb_ready_unused = hb.HB_up_ready;
  assign hb.HB_up_valid  = 1'b0;
  assign hb.HB_up_data   = '0;
`endif

endmodule : time_mgr
